// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID/EX stage and its forwarding logic.
package pipeline_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_NE  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_LT  = 4'b1010;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand source selection for the EX stage; the younger EX/MEM producer wins, x0 never forwards.
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_i,
    input  logic                      exmem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr_i,
    input  logic                      memwb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr_i,
    output fwd_sel_e                  fwd_a_o,
    output fwd_sel_e                  fwd_b_o
);

    function automatic fwd_sel_e pick(input logic [REG_ADDR_WIDTH-1:0] src);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_o = pick(ex_rs1_addr_i);
        fwd_b_o = pick(ex_rs2_addr_i);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush priority
// and forwarded ALU operand selection.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      load_use_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write
);

    logic                      valid_q,    valid_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
    logic [DATA_WIDTH-1:0]     imm_q,      imm_d;
    ex_ctrl_t                  ctrl_q,     ctrl_d;

    logic                      lu_hazard;
    logic                      bubble;
    fwd_sel_e                  fwd_a;
    fwd_sel_e                  fwd_b;
    logic [DATA_WIDTH-1:0]     rs1_fwd;
    logic [DATA_WIDTH-1:0]     rs2_fwd;

    // Flush squashes the producer/consumer pair, so no hazard is reported.
    assign lu_hazard = ~flush & valid_q & ctrl_q.mem_read & (rd_addr_q != '0) & id_valid
                     & ((id_rs1_addr == rd_addr_q) | (id_rs2_addr == rd_addr_q));
    assign bubble    = flush | lu_hazard;

    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        if (bubble) begin
            valid_d    = 1'b0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            imm_d      = '0;
            ctrl_d     = '0;
        end else if (!stall) begin
            valid_d          = id_valid;
            rs1_data_d       = id_rs1_data;
            rs2_data_d       = id_rs2_data;
            rs1_addr_d       = id_rs1_addr;
            rs2_addr_d       = id_rs2_addr;
            rd_addr_d        = id_rd_addr;
            imm_d            = id_imm;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            ctrl_d.mem_write = id_mem_write;
            ctrl_d.alu_src   = id_alu_src;
            ctrl_d.alu_op    = id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
        end
    end

    forwarding_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd (
        .ex_rs1_addr_i    (rs1_addr_q),
        .ex_rs2_addr_i    (rs2_addr_q),
        .exmem_reg_write_i(exmem_reg_write),
        .exmem_rd_addr_i  (exmem_rd_addr),
        .memwb_reg_write_i(memwb_reg_write),
        .memwb_rd_addr_i  (memwb_rd_addr),
        .fwd_a_o          (fwd_a),
        .fwd_b_o          (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: rs1_fwd = exmem_result;
            FWD_MEMWB: rs1_fwd = memwb_result;
            default:   rs1_fwd = rs1_data_q;
        endcase
        case (fwd_b)
            FWD_EXMEM: rs2_fwd = exmem_result;
            FWD_MEMWB: rs2_fwd = memwb_result;
            default:   rs2_fwd = rs2_data_q;
        endcase
    end

    assign load_use_stall = lu_hazard;
    assign ex_valid       = valid_q;
    assign SrcA           = rs1_fwd;
    assign SrcB           = ctrl_q.alu_src ? imm_q : rs2_fwd;
    assign ex_store_data  = rs2_fwd;
    assign Operation      = ctrl_q.alu_op;
    assign ex_rd_addr     = rd_addr_q;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model of the EX slot.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall, ex_valid;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int tests = 0;
    int fails = 0;

    // model of the instruction currently occupying EX
    typedef struct {
        bit        valid;
        bit [31:0] rs1d, rs2d, imm;
        bit [4:0]  rs1a, rs2a, rd;
        bit        src, rw, mr, mw;
        bit [3:0]  op;
    } slot_t;
    slot_t m;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] fwd_val(input bit [4:0] a, input bit [31:0] regv);
        if (exmem_reg_write && exmem_rd_addr != 0 && exmem_rd_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr != 0 && memwb_rd_addr == a) return memwb_result;
        return regv;
    endfunction

    function automatic bit exp_lu();
        return !flush && m.valid && m.mr && m.rd != 0 && id_valid &&
               (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
    endfunction

    task automatic check_all(input string ctx);
        bit [31:0] a, b;
        a = fwd_val(m.rs1a, m.rs1d);
        b = fwd_val(m.rs2a, m.rs2d);
        chk({ctx, ".ex_valid"},      ex_valid,       m.valid);
        chk({ctx, ".SrcA"},          SrcA,           a);
        chk({ctx, ".SrcB"},          SrcB,           m.src ? m.imm : b);
        chk({ctx, ".store_data"},    ex_store_data,  b);
        chk({ctx, ".Operation"},     Operation,      m.op);
        chk({ctx, ".rd"},            ex_rd_addr,     m.rd);
        chk({ctx, ".ctrl"},          {ex_reg_write, ex_mem_read, ex_mem_write}, {m.rw, m.mr, m.mw});
        chk({ctx, ".load_use"},      load_use_stall, exp_lu());
    endtask

    task automatic clear_model();
        m = '{default: 0};
    endtask

    // check outputs with current inputs, clock once, advance model, return at negedge
    task automatic step(input string ctx);
        bit lu;
        #1;
        check_all(ctx);
        lu = exp_lu();
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else if (flush || lu) begin
            clear_model();
        end else if (!stall) begin
            m.valid = id_valid; m.rs1d = id_rs1_data; m.rs2d = id_rs2_data; m.imm = id_imm;
            m.rs1a = id_rs1_addr; m.rs2a = id_rs2_addr; m.rd = id_rd_addr;
            m.src = id_alu_src; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            m.op = id_alu_op;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [31:0] d1,
                          input bit [4:0] r2, input bit [31:0] d2, input bit [4:0] rd,
                          input bit [31:0] imm, input bit src, input bit [3:0] op,
                          input bit rw, input bit mr, input bit mw);
        id_valid = v; id_rs1_addr = r1; id_rs1_data = d1; id_rs2_addr = r2; id_rs2_data = d2;
        id_rd_addr = rd; id_imm = imm; id_alu_src = src; id_alu_op = op;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input bit ew, input bit [4:0] ea, input bit [31:0] er,
                           input bit ww, input bit [4:0] wa, input bit [31:0] wr);
        exmem_reg_write = ew; exmem_rd_addr = ea; exmem_result = er;
        memwb_reg_write = ww; memwb_rd_addr = wa; memwb_result = wr;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        clear_model();

        // reset: everything zero
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.ex_valid", ex_valid, 0);
        chk("rst.SrcA", SrcA, 0);
        chk("rst.SrcB", SrcB, 0);
        chk("rst.store", ex_store_data, 0);
        chk("rst.Operation", Operation, 0);
        chk("rst.load_use", load_use_stall, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x2, x1, 7 with x1 = 5
        set_id(1, 1, 5, 0, 0, 2, 7, 1, 4'b0010, 1, 0, 0);
        step("addi");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("addi.SrcA", SrcA, 32'd5);
        chk("addi.SrcB", SrcB, 32'd7);
        chk("addi.Operation", Operation, 4'b0010);
        chk("addi.ex_valid", ex_valid, 1);

        // forwarding priority on rs1 = x3, held in EX by stall
        set_id(1, 3, 32'h11, 3, 32'h22, 5, 0, 0, 4'b0000, 1, 0, 0);
        step("fwd_load");
        stall = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        #1 chk("fwd.exmem_wins", SrcA, 32'hAA);
        step("fwd_both");
        set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
        #1 chk("fwd.memwb", SrcA, 32'hBB);
        chk("fwd.memwb_store", ex_store_data, 32'hBB);
        step("fwd_memwb");
        set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
        #1 chk("fwd.x0_regdata", SrcA, 32'h11);
        step("fwd_x0");
        stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);

        // load-use: LW x4 in EX, consumer reads x4 as rs2
        set_id(1, 1, 32'h100, 0, 0, 4, 32'h8, 1, 4'b0010, 1, 1, 0);
        step("lw");
        set_id(1, 6, 32'h40, 4, 32'hDEAD, 0, 32'h4, 1, 4'b0010, 0, 0, 1);
        #1 chk("lu.asserted", load_use_stall, 1);
        step("lu_bubble");
        #1 chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.clear", load_use_stall, 0);
        step("lu_enter");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 1, 4, 32'h1234);
        #1 chk("lu.store_fwd", ex_store_data, 32'h1234);
        chk("lu.consumer_valid", ex_valid, 1);
        step("lu_fwd");
        set_fwd(0, 0, 0, 0, 0, 0);

        // stall 3 cycles, outputs held
        set_id(1, 7, 32'h77, 8, 32'h88, 9, 0, 0, 4'b0110, 1, 0, 0);
        step("stall_load");
        stall = 1'b1;
        set_id(1, 10, 32'h1, 11, 32'h2, 12, 32'h3, 1, 4'b0011, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            chk("stall.SrcA", SrcA, 32'h77);
            chk("stall.SrcB", SrcB, 32'h88);
            chk("stall.Operation", Operation, 4'b0110);
        end
        flush = 1'b1;
        step("flush_stall");
        chk("flush_stall.valid", ex_valid, 0);
        stall = 1'b0; flush = 1'b0;

        // flush overrides load-use detection
        set_id(1, 0, 0, 0, 0, 13, 0, 1, 4'b0010, 1, 1, 0);
        step("lw2");
        set_id(1, 13, 0, 0, 0, 14, 0, 0, 4'b0001, 1, 0, 0);
        flush = 1'b1;
        #1 chk("flush.lu_gated", load_use_stall, 0);
        step("flush_lu");
        flush = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 5)), $urandom,
                   5'($urandom_range(0, 5)), $urandom, 5'($urandom_range(0, 5)), $urandom,
                   1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 1) == 1, 1'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 5)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 5)), $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        stall = 1'b0; flush = 1'b0;

        // async reset between edges
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 32'h55, 2, 32'h66, 3, 32'h9, 0, 4'b1010, 1, 0, 1);
        step("pre_rst");
        #1 chk("arst.pre_valid", ex_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", ex_valid, 0);
        chk("arst.SrcA", SrcA, 0);
        chk("arst.SrcB", SrcB, 0);
        chk("arst.Operation", Operation, 0);
        chk("arst.ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
